// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: default sizing constants and
// the FSM state encoding.
package layer_sequencer_pkg;

  localparam int LS_DATA_WIDTH = 8;
  localparam int LS_TIMEOUT    = 64;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/layer_sequencer.sv
// Layer sequencer: accepts one input vector, streams its elements into the
// first cell of a layer chain, collects the per-cell results returned by the
// scaler into a register file, and hands the completed result vector to the
// consumer. A watchdog aborts the layer if the scaler stops answering.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = LS_DATA_WIDTH,
  parameter int INPUT_AMOUNT = 4,
  parameter int CELL_AMOUNT  = 4,
  parameter int TIMEOUT      = LS_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*INPUT_AMOUNT-1:0] in_vector,
  output logic [DATA_WIDTH+1:0]            layer_index,
  output logic [DATA_WIDTH-1:0]            layer_value,
  output logic                             layer_enable,
  input  logic [DATA_WIDTH+1:0]            scaler_index,
  input  logic [DATA_WIDTH-1:0]            scaler_value,
  input  logic                             scaler_enable,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*CELL_AMOUNT-1:0] out_vector,
  output logic                             busy,
  output logic                             timeout_error
);

  localparam int IDX_W = DATA_WIDTH + 2;
  localparam int CNT_W = (INPUT_AMOUNT > 1) ? $clog2(INPUT_AMOUNT) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(INPUT_AMOUNT - 1);
  localparam logic [TMR_W-1:0] LAST_TMR   = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] CELL_LIMIT = IDX_W'(CELL_AMOUNT);

  logic [1:0]                        r_state;
  logic                              r_in_ready;
  logic [DATA_WIDTH*INPUT_AMOUNT-1:0] r_vector;
  logic [CNT_W-1:0]                  r_count;
  logic [TMR_W-1:0]                  r_timer;
  logic [CELL_AMOUNT-1:0]            r_mask;
  logic [DATA_WIDTH*CELL_AMOUNT-1:0] r_out_vector;
  logic                              r_out_valid;
  logic                              r_timeout_error;
  logic                              r_layer_enable;
  logic [IDX_W-1:0]                  r_layer_index;
  logic [DATA_WIDTH-1:0]             r_layer_value;

  logic                              w_in_hs;
  logic                              w_capture;
  logic [CELL_AMOUNT-1:0]            w_hit;
  logic [CELL_AMOUNT-1:0]            w_mask_next;
  logic                              w_full;
  logic [CNT_W-1:0]                  w_next_cnt;
  logic [DATA_WIDTH-1:0]             w_next_elem;

  assign w_in_hs     = in_valid & r_in_ready;
  assign w_capture   = scaler_enable && (r_state == ST_STREAM || r_state == ST_WAIT)
                       && (scaler_index < CELL_LIMIT);
  assign w_mask_next = r_mask | w_hit;
  assign w_full      = &w_mask_next;
  assign w_next_cnt  = r_count + 1'b1;

  // Decode the returned scaler index into a one-hot cell select.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < CELL_AMOUNT; k++) begin
      if (w_capture && scaler_index == IDX_W'(k)) w_hit[k] = 1'b1;
    end
  end

  // Pick the element that goes out on the next streaming cycle.
  always_comb begin
    w_next_elem = '0;
    for (int k = 0; k < INPUT_AMOUNT; k++) begin
      if (w_next_cnt == CNT_W'(k)) w_next_elem = r_vector[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Sequencer FSM with registered chain outputs and the result capture file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_in_ready      <= 1'b0;
      r_vector        <= '0;
      r_count         <= '0;
      r_timer         <= '0;
      r_mask          <= '0;
      r_out_vector    <= '0;
      r_out_valid     <= 1'b0;
      r_timeout_error <= 1'b0;
      r_layer_enable  <= 1'b0;
      r_layer_index   <= '0;
      r_layer_value   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_in_hs) begin
            // The first element is launched straight from the input so the
            // stream starts the cycle right after the handshake.
            r_vector        <= in_vector;
            r_count         <= '0;
            r_timer         <= '0;
            r_mask          <= '0;
            r_timeout_error <= 1'b0;
            r_layer_enable  <= 1'b1;
            r_layer_index   <= '0;
            r_layer_value   <= in_vector[DATA_WIDTH-1:0];
            r_in_ready      <= 1'b0;
            r_state         <= ST_STREAM;
          end
        end
        ST_STREAM, ST_WAIT: begin
          for (int k = 0; k < CELL_AMOUNT; k++) begin
            if (w_hit[k]) r_out_vector[k*DATA_WIDTH +: DATA_WIDTH] <= scaler_value;
          end
          r_mask <= w_mask_next;
          if (w_full) begin
            // All cells reported: finish even if streaming is not over.
            r_out_valid    <= 1'b1;
            r_layer_enable <= 1'b0;
            r_layer_index  <= '0;
            r_layer_value  <= '0;
            r_state        <= ST_DONE;
          end else if (r_state == ST_STREAM) begin
            if (r_count == LAST_CNT) begin
              r_layer_enable <= 1'b0;
              r_layer_index  <= '0;
              r_layer_value  <= '0;
              r_timer        <= '0;
              r_state        <= ST_WAIT;
            end else begin
              r_count       <= w_next_cnt;
              r_layer_index <= IDX_W'(w_next_cnt);
              r_layer_value <= w_next_elem;
            end
          end else if (r_timer == LAST_TMR) begin
            // Scaler went silent: flag it and drop the partial result.
            r_timeout_error <= 1'b1;
            r_mask          <= '0;
            r_out_vector    <= '0;
            r_in_ready      <= 1'b1;
            r_state         <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign layer_enable  = r_layer_enable;
  assign layer_index   = r_layer_index;
  assign layer_value   = r_layer_value;
  assign out_valid     = r_out_valid;
  assign out_vector    = r_out_vector;
  assign busy          = (r_state != ST_IDLE);
  assign timeout_error = r_timeout_error;

endmodule
